// File: rtl/ctrl_credit_dispatcher.sv
// Credit-aware round-robin engine dispatcher; each selection is broadcast to REPLICATED_OUT_NUM
// independently handshaken consumers. Define CTRL_DISPATCH_STALL_CNT_EN to add the stall_cnt output.
module ctrl_credit_dispatcher #(
  parameter int D_COUNT            = 2,
  parameter int DISPATCH_WIDTH     = $clog2(D_COUNT),
  parameter int REPLICATED_OUT_NUM = 3,
  parameter int CREDITS            = 4,
  parameter int CREDIT_WIDTH       = $clog2(CREDITS + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [D_COUNT-1:0]                           s_engine_enable,
  input  logic [D_COUNT-1:0]                           s_credit_return,
  output logic [REPLICATED_OUT_NUM*DISPATCH_WIDTH-1:0] m_dispatcher_tdata,
  output logic [REPLICATED_OUT_NUM-1:0]                m_dispatcher_tvalid,
  input  logic [REPLICATED_OUT_NUM-1:0]                m_dispatcher_tready,
  output logic                                         credit_err
`ifdef CTRL_DISPATCH_STALL_CNT_EN
  ,
  output logic [31:0]                                  stall_cnt
`endif
);

  typedef enum logic {ST_SELECT, ST_OFFER} state_t;

  state_t                        state, state_d;
  logic [DISPATCH_WIDTH-1:0]     sel, rr_ptr, pick;
  logic [REPLICATED_OUT_NUM-1:0] done, done_d, hs, done_acc;
  logic [CREDIT_WIDTH-1:0]       credit [D_COUNT];
  logic [D_COUNT-1:0]            eligible, take;
  logic                          any_elig, offer_done, issue;

  // Eligibility uses the registered credit, so a same-cycle return only helps next cycle.
  always_comb begin
    for (int i = 0; i < D_COUNT; i++) begin
      eligible[i] = s_engine_enable[i] && (credit[i] != '0);
    end
  end

  // Scan from the far end back toward rr_ptr so the closest eligible index wins.
  always_comb begin
    any_elig = 1'b0;
    pick     = '0;
    for (int off = D_COUNT - 1; off >= 0; off--) begin
      int idx;
      idx = (int'(rr_ptr) + off) % D_COUNT;
      if (eligible[idx[DISPATCH_WIDTH-1:0]]) begin
        any_elig = 1'b1;
        pick     = idx[DISPATCH_WIDTH-1:0];
      end
    end
  end

  assign m_dispatcher_tvalid = (state == ST_OFFER) ? ~done : '0;
  assign m_dispatcher_tdata  = {REPLICATED_OUT_NUM{sel}};

  // Next-state: the final handshake of an offer re-runs selection in the same cycle.
  always_comb begin
    hs         = m_dispatcher_tvalid & m_dispatcher_tready;
    done_acc   = done | hs;
    offer_done = (state == ST_OFFER) && (&done_acc);
    issue      = any_elig && ((state == ST_SELECT) || offer_done);
    take       = issue ? (D_COUNT'(1) << pick) : '0;
    state_d    = state;
    done_d     = done;
    if (issue) begin
      state_d = ST_OFFER;
      done_d  = '0;
    end else if (state == ST_OFFER) begin
      done_d = done_acc;
      if (offer_done) state_d = ST_SELECT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SELECT;
      done  <= '0;
    end else begin
      state <= state_d;
      done  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel    <= '0;
      rr_ptr <= '0;
    end else if (issue) begin
      sel    <= pick;
      rr_ptr <= (pick == DISPATCH_WIDTH'(D_COUNT - 1)) ? '0 : pick + 1'b1;
    end
  end

  // NOTE: the credit array is reset explicitly; its contents are live state, not scratch storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D_COUNT; i++) credit[i] <= CREDIT_WIDTH'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      for (int i = 0; i < D_COUNT; i++) begin
        if (s_credit_return[i] && !take[i]) begin
          if (credit[i] == CREDIT_WIDTH'(CREDITS)) credit_err <= 1'b1;
          else                                     credit[i]  <= credit[i] + 1'b1;
        end else if (!s_credit_return[i] && take[i]) begin
          credit[i] <= credit[i] - 1'b1;
        end
      end
    end
  end

`ifdef CTRL_DISPATCH_STALL_CNT_EN
  logic stall;

  assign stall = ((state == ST_SELECT) && !any_elig) ||
                 ((state == ST_OFFER) && (|(m_dispatcher_tvalid & ~m_dispatcher_tready)));

  always_ff @(posedge clk) begin
    if (rst)                              stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))  stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ctrl_credit_dispatcher.sv
// Directed bench for ctrl_credit_dispatcher (D_COUNT=2, CREDITS=2, REPLICATED_OUT_NUM=3);
// stall_cnt is also checked when CTRL_DISPATCH_STALL_CNT_EN is defined.
module tb_ctrl_credit_dispatcher;

  localparam int DC  = 2;
  localparam int DW  = 1;
  localparam int RON = 3;
  localparam int CR  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [DC-1:0]  en, ret;
  logic [RON-1:0] rdy, tvalid;
  logic [RON*DW-1:0] tdata;
  logic           err;
`ifdef CTRL_DISPATCH_STALL_CNT_EN
  logic [31:0]    stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  ctrl_credit_dispatcher #(
    .D_COUNT(DC), .DISPATCH_WIDTH(DW), .REPLICATED_OUT_NUM(RON), .CREDITS(CR)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_engine_enable     (en),
    .s_credit_return     (ret),
    .m_dispatcher_tdata  (tdata),
    .m_dispatcher_tvalid (tvalid),
    .m_dispatcher_tready (rdy),
    .credit_err          (err)
`ifdef CTRL_DISPATCH_STALL_CNT_EN
    ,
    .stall_cnt           (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [RON*DW-1:0] rep(input int idx);
    logic [RON*DW-1:0] r;
    r = '0;
    for (int k = 0; k < RON; k++) r[k*DW +: DW] = DW'(idx);
    return r;
  endfunction

  // Outputs are sampled 1 time unit after the edge; inputs set here apply to the coming edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_offer(input string tag, input logic [RON-1:0] v, input int idx);
    check({tag, "_valid"}, 32'(tvalid), 32'(v));
    check({tag, "_data"},  32'(tdata),  32'(rep(idx)));
  endtask

  task automatic expect_stall(input string tag, input int n);
`ifdef CTRL_DISPATCH_STALL_CNT_EN
    check(tag, stall_cnt, 32'(n));
`endif
  endtask

  initial begin
    rst = 1'b1; en = 2'b11; ret = 2'b00; rdy = 3'b111;
    step(); step();
    check("rst_valid", 32'(tvalid), 32'd0);
    check("rst_data",  32'(tdata),  32'd0);
    check("rst_err",   32'(err),    32'd0);
    expect_stall("rst_stall", 0);

    // 1: back-to-back 0,1,0,1 then credits exhausted
    rst = 1'b0;                                       // cycle 0
    for (int c = 0; c < 4; c++) begin
      step();                                         // cycles 1..4
      expect_offer("s1_seq", 3'b111, c % 2);
    end
    step();                                           // cycle 5
    check("s1_drop", 32'(tvalid), 32'd0);
    expect_stall("s1_stall0", 0);
    step();                                           // cycle 6
    check("s1_idle", 32'(tvalid), 32'd0);
    expect_stall("s1_stall1", 1);

    // 2: credit return to engine 1 -> one issue of index 1
    ret = 2'b10;
    step();                                           // cycle 7
    ret = 2'b00;
    check("s2_wait", 32'(tvalid), 32'd0);
    step();                                           // cycle 8
    expect_offer("s2_issue", 3'b111, 1);
    step();                                           // cycle 9
    check("s2_drop", 32'(tvalid), 32'd0);
    expect_stall("s2_stall", 2);

    // 3: partial handshakes hold index 0, then index 1 right after
    ret = 2'b11;
    step();                                           // cycle 10
    ret = 2'b00; rdy = 3'b001;
    step();                                           // cycle 11
    expect_offer("s3_hold0", 3'b111, 0);
    step();                                           // cycle 12
    expect_offer("s3_hold1", 3'b110, 0);
    step();                                           // cycle 13
    expect_offer("s3_hold2", 3'b110, 0);
    step();                                           // cycle 14
    expect_offer("s3_last", 3'b110, 0);
    rdy = 3'b110;
    step();                                           // cycle 15
    expect_offer("s3_next", 3'b111, 1);
    rdy = 3'b111;
    step();                                           // cycle 16
    check("s3_drop", 32'(tvalid), 32'd0);
    expect_stall("s3_stall", 6);

    // 4: engine 1 disabled -> only index 0; re-enable -> 1 follows 0
    en = 2'b01; ret = 2'b01;
    step();                                           // cycle 17
    for (int c = 0; c < 3; c++) begin
      step();                                         // cycles 18..20
      expect_offer("s4_only0", 3'b111, 0);
    end
    en = 2'b11; ret = 2'b11;
    step();                                           // cycle 21
    ret = 2'b00;
    expect_offer("s4_last0", 3'b111, 0);
    step();                                           // cycle 22
    expect_offer("s4_reen1", 3'b111, 1);
    step();                                           // cycle 23
    expect_offer("s4_back0", 3'b111, 0);
    step();                                           // cycle 24
    check("s4_drop", 32'(tvalid), 32'd0);
    expect_stall("s4_stall", 7);

    // 5: overfill engine 0 -> sticky credit_err; take+return is net zero
    en = 2'b00; ret = 2'b01;
    step();                                           // cycle 25
    step();                                           // cycle 26
    check("s5_err_pre", 32'(err), 32'd0);
    step();                                           // cycle 27
    check("s5_err_set", 32'(err), 32'd1);
    en = 2'b01; ret = 2'b01;
    step();                                           // cycle 28
    ret = 2'b00;
    expect_offer("s5_take0", 3'b111, 0);
    step();                                           // cycle 29
    expect_offer("s5_take1", 3'b111, 0);
    step();                                           // cycle 30
    expect_offer("s5_take2", 3'b111, 0);
    step();                                           // cycle 31
    check("s5_drop", 32'(tvalid), 32'd0);
    check("s5_err_hold", 32'(err), 32'd1);

    // 6: reset during a partially accepted offer
    en = 2'b11; ret = 2'b11;
    step();                                           // cycle 32
    ret = 2'b00; rdy = 3'b001;
    step();                                           // cycle 33
    expect_offer("s6_offer", 3'b111, 1);
    step();                                           // cycle 34
    check("s6_partial", 32'(tvalid), 32'(3'b110));
    rst = 1'b1;
    step();                                           // cycle 35
    check("s6_rst_valid", 32'(tvalid), 32'd0);
    check("s6_rst_data",  32'(tdata),  32'd0);
    check("s6_rst_err",   32'(err),    32'd0);
    expect_stall("s6_rst_stall", 0);
    rst = 1'b0; rdy = 3'b111;
    for (int c = 0; c < 4; c++) begin
      step();                                         // cycles 36..39
      expect_offer("s6_seq", 3'b111, c % 2);
    end
    step();                                           // cycle 40
    check("s6_drop", 32'(tvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_credit_dispatcher.md
Name: ctrl_credit_dispatcher

Overview:
- Credit-aware replacement for the plain round-robin dispatcher in front of the replicated engine pipelines.
- Picks the next engine index round-robin, skipping engines that have no free credit or are disabled.
- Broadcasts the chosen index to REPLICATED_OUT_NUM consumers (parser, payload buffer, context fetch). Each consumer handshakes independently.
- Engines return one credit per completed event. This bounds in-flight work per engine to CREDITS.

Parameters:
- D_COUNT, 2: number of engines. Legal range 2..64.
- DISPATCH_WIDTH, $clog2(D_COUNT): width of the engine index.
- REPLICATED_OUT_NUM, 3: number of consumers of each selection.
- CREDITS, 4: initial and maximum credits per engine. Legal range 1..255.
- CREDIT_WIDTH, $clog2(CREDITS+1): width of each credit counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- s_engine_enable, input, D_COUNT: per-engine enable mask. Sampled every cycle.
- s_credit_return, input, D_COUNT: bit i high returns one credit to engine i in that cycle.
- m_dispatcher_tdata, output, REPLICATED_OUT_NUM*DISPATCH_WIDTH: selected engine index. The same index is replicated into every slice.
- m_dispatcher_tvalid, output, REPLICATED_OUT_NUM: per-consumer valid.
- m_dispatcher_tready, input, REPLICATED_OUT_NUM: per-consumer ready.
- credit_err, output, 1: sticky flag. Set on a credit return to an engine that is already full.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values:
  - credit[i] = CREDITS; rr_ptr = 0.
  - State = SELECT; done mask = 0.
  - m_dispatcher_tdata = 0; m_dispatcher_tvalid = 0; credit_err = 0.
- Reset mid-OFFER: the offer is abandoned. tvalid is low in the cycle after rst is sampled. Credits restore to CREDITS.
- Eligibility: engine i is eligible when s_engine_enable[i] is high and credit[i] != 0. A credit returned in the same cycle does not make the engine eligible until the next cycle.
- Selection: the first eligible index scanning rr_ptr, rr_ptr+1, … up to D_COUNT-1, then wrapping to 0.
- State SELECT:
  - If any engine is eligible: register sel, drive sel on all tdata slices, set all tvalid bits, clear the done mask, decrement credit[sel], set rr_ptr to (sel == D_COUNT-1) ? 0 : sel+1, and go to OFFER.
  - If no engine is eligible: stay in SELECT with tvalid = 0.
- State OFFER:
  - Per consumer k: tvalid[k] = !done[k]. A handshake (tvalid[k] && tready[k]) sets done[k].
  - tdata stays stable until every bit of the done mask is set.
  - When the last outstanding handshake occurs in cycle t, selection for the next cycle runs in that same cycle (same rule as SELECT). A new index is therefore valid at t+1, giving back-to-back dispatch at one selection per cycle when all tready are high. If nothing is eligible, go to SELECT.
  - A disable arriving during OFFER does not retract the current offer.
- Credit arithmetic, per engine per cycle: credit_next = credit + return - take.
  - return and take in the same cycle: net zero.
  - Return when credit == CREDITS and no take: credit saturates at CREDITS and credit_err is set. Only rst clears credit_err.
- Latency: from reset release, or from an eligible engine appearing, to tvalid high is 1 cycle.
- Ordering: selections are issued in round-robin order over eligible engines. No engine is selected twice in a row while another engine is eligible.

Optional Feature:
- Macro: CTRL_DISPATCH_STALL_CNT_EN.
- With the macro defined:
  - Adds output stall_cnt, 32 bits, reset 0.
  - Increments once per cycle that the block is in SELECT with no engine eligible, or in OFFER with at least one tvalid high and its tready low.
  - Saturates at 0xFFFFFFFF.
- Without the macro: no port and no counter logic.

Test Plan (D_COUNT=2, CREDITS=2, REPLICATED_OUT_NUM=3 unless noted):
1. Release rst with all tready=1, enables=2'b11, no returns -> tdata sequence 0,1,0,1 on cycles 1-4. tvalid then drops; credits are 0,0.
2. Continue from (1); pulse s_credit_return=2'b10 -> next selection is 1, one cycle later, then tvalid returns low.
3. tready=3'b001 for 3 cycles, then 3'b110 -> index 0 is held with tvalid 3'b111, then 3'b110, then accepted. The next index 1 appears on the cycle after the final handshake.
4. enables=2'b01 with returns keeping credits nonzero -> only index 0 is ever issued. Re-enable engine 1 -> the next issue after index 0 is 1.
5. Return to engine 0 while credit[0]=2 -> credit stays 2 and credit_err=1, held until rst. A simultaneous take plus return on engine 0 leaves the credit unchanged.
6. Assert rst mid-OFFER with partial done mask -> tvalid=0 on the next cycle. After release, the first index is 0 and credits are full. With CTRL_DISPATCH_STALL_CNT_EN defined, stall_cnt=0 after reset and counts exactly the starved cycles of scenario 1's tail.
